h2f_reg_arbiter: RTL and testbench

Two-master Avalon-MM arbiter that shares the single h2f register-bank slave port between the HPS lightweight bridge (master 0) and a fabric-side requester (master 1). It grants one master at a time in round-robin order and keeps one transaction outstanding. It registers the command toward the bank and the response back to the granted master. A watchdog aborts bank transactions that never complete, so a hung slave cannot lock up the HPS bus.

---
 rtl/h2f_reg_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_h2f_reg_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/h2f_reg_arbiter.sv
// Round-robin arbiter sharing the h2f register-bank slave between the HPS lightweight bridge
// (master 0) and a fabric requester (master 1), with a watchdog that aborts hung bank cycles.
module h2f_reg_arbiter #(
    parameter int unsigned ADDRWIDTH      = 10,
    parameter int unsigned DATAWIDTH      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     m0_read,
    input  logic                     m0_write,
    input  logic [ADDRWIDTH-1:0]     m0_address,
    input  logic [DATAWIDTH-1:0]     m0_writedata,
    input  logic [DATAWIDTH/8-1:0]   m0_byteenable,
    output logic [DATAWIDTH-1:0]     m0_readdata,
    output logic                     m0_readdatavalid,
    output logic                     m0_waitrequest,

    input  logic                     m1_read,
    input  logic                     m1_write,
    input  logic [ADDRWIDTH-1:0]     m1_address,
    input  logic [DATAWIDTH-1:0]     m1_writedata,
    input  logic [DATAWIDTH/8-1:0]   m1_byteenable,
    output logic [DATAWIDTH-1:0]     m1_readdata,
    output logic                     m1_readdatavalid,
    output logic                     m1_waitrequest,

    output logic                     s_read,
    output logic                     s_write,
    output logic [ADDRWIDTH-1:0]     s_address,
    output logic [DATAWIDTH-1:0]     s_writedata,
    output logic [DATAWIDTH/8-1:0]   s_byteenable,
    input  logic [DATAWIDTH-1:0]     s_readdata,
    input  logic                     s_readdatavalid,
    input  logic                     s_waitrequest,

    output logic [1:0]               grant_o,
    output logic                     timeout_o,
    output logic [7:0]               err_count_o
);

    localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StResp, StRel} state_e;

    state_e                  state_q;
    logic                    last_grant_q;
    logic [CntWidth-1:0]     cnt_q;
    logic                    is_write_q;
    logic                    wait_seen_q;
    logic                    rdv_seen_q;
    logic [DATAWIDTH-1:0]    data_q;

    logic                    req0;
    logic                    req1;
    logic                    pick1;
    logic                    sel_write;
    logic [ADDRWIDTH-1:0]    sel_address;
    logic [DATAWIDTH-1:0]    sel_writedata;
    logic [DATAWIDTH/8-1:0]  sel_byteenable;
    logic                    wait_seen;
    logic                    rdv_seen;
    logic                    complete;
    logic                    abort;
    logic [DATAWIDTH-1:0]    resp_data;

    always_comb begin
        req0           = m0_read | m0_write;
        req1           = m1_read | m1_write;
        // On a tie the master that did not own the last transaction wins.
        pick1          = req1 & (~req0 | ~last_grant_q);
        sel_write      = pick1 ? m1_write      : m0_write;
        sel_address    = pick1 ? m1_address    : m0_address;
        sel_writedata  = pick1 ? m1_writedata  : m0_writedata;
        sel_byteenable = pick1 ? m1_byteenable : m0_byteenable;

        // Reads may see the accept and the data qualifier in either order.
        wait_seen      = wait_seen_q | ~s_waitrequest;
        rdv_seen       = rdv_seen_q | s_readdatavalid;
        complete       = is_write_q ? ~s_waitrequest : (wait_seen & rdv_seen);
        abort          = ~complete & (cnt_q == CntLast);
        resp_data      = abort ? '1 : (s_readdatavalid ? s_readdata : data_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            last_grant_q     <= 1'b1;
            cnt_q            <= '0;
            is_write_q       <= 1'b0;
            wait_seen_q      <= 1'b0;
            rdv_seen_q       <= 1'b0;
            data_q           <= '0;
            m0_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m0_waitrequest   <= 1'b1;
            m1_readdata      <= '0;
            m1_readdatavalid <= 1'b0;
            m1_waitrequest   <= 1'b1;
            s_read           <= 1'b0;
            s_write          <= 1'b0;
            s_address        <= '0;
            s_writedata      <= '0;
            s_byteenable     <= '0;
            grant_o          <= 2'b00;
            timeout_o        <= 1'b0;
            err_count_o      <= 8'd0;
        end else begin
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            timeout_o        <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (req0 | req1) begin
                        state_q      <= StIssue;
                        grant_o      <= pick1 ? 2'b10 : 2'b01;
                        is_write_q   <= sel_write;
                        s_write      <= sel_write;
                        s_read       <= ~sel_write;
                        s_address    <= sel_address;
                        s_writedata  <= sel_writedata;
                        s_byteenable <= sel_byteenable;
                        cnt_q        <= '0;
                        wait_seen_q  <= 1'b0;
                        rdv_seen_q   <= 1'b0;
                    end
                end

                StIssue: begin
                    cnt_q <= cnt_q + CntWidth'(1);
                    if (!s_waitrequest) begin
                        wait_seen_q <= 1'b1;
                        s_read      <= 1'b0;
                        s_write     <= 1'b0;
                    end
                    if (s_readdatavalid) begin
                        rdv_seen_q <= 1'b1;
                        data_q     <= s_readdata;
                    end
                    if (complete || abort) begin
                        state_q <= StResp;
                        s_read  <= 1'b0;
                        s_write <= 1'b0;
                        if (grant_o[0]) begin
                            m0_waitrequest   <= 1'b0;
                            m0_readdatavalid <= ~is_write_q;
                            if (!is_write_q) begin
                                m0_readdata <= resp_data;
                            end
                        end
                        if (grant_o[1]) begin
                            m1_waitrequest   <= 1'b0;
                            m1_readdatavalid <= ~is_write_q;
                            if (!is_write_q) begin
                                m1_readdata <= resp_data;
                            end
                        end
                        if (abort) begin
                            timeout_o <= 1'b1;
                            if (err_count_o != 8'hFF) begin
                                err_count_o <= err_count_o + 8'd1;
                            end
                        end
                    end
                end

                StResp: begin
                    state_q        <= StRel;
                    last_grant_q   <= grant_o[1];
                    grant_o        <= 2'b00;
                    m0_waitrequest <= 1'b1;
                    m1_waitrequest <= 1'b1;
                end

                // One dead cycle lets the served master retire its strobe before re-arbitration.
                StRel: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_h2f_reg_arbiter.sv
// Randomized bench for h2f_reg_arbiter: a transaction-level model of arbitration, bank memory
// and the watchdog predicts every master- and bank-side observation cycle by cycle.
module tb_h2f_reg_arbiter;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [AW-1:0] m0_address, m1_address;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest;
    logic          s_read, s_write;
    logic [AW-1:0] s_address;
    logic [DW-1:0] s_writedata, s_readdata;
    logic [BW-1:0] s_byteenable;
    logic          s_readdatavalid, s_waitrequest;
    logic [1:0]    grant_o;
    logic          timeout_o;
    logic [7:0]    err_count_o;

    always #5 clk = ~clk;

    h2f_reg_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m0_waitrequest(m0_waitrequest),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .m1_waitrequest(m1_waitrequest),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .s_waitrequest(s_waitrequest),
        .grant_o(grant_o), .timeout_o(timeout_o), .err_count_o(err_count_o)
    );

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } cmd_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] bank_mem [1024];
    bit          pend0, pend1;
    cmd_t        c0, c1;
    int          last_w;
    logic [DW-1:0] exp_rd0, exp_rd1;
    int          exp_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        int op = $urandom_range(0, 3);
        c.rd    = (op != 2);
        c.wr    = (op >= 2);
        c.addr  = AW'($urandom_range(0, 15));
        c.wdata = {$urandom, $urandom};
        c.be    = BW'($urandom);
        return c;
    endfunction

    function automatic cmd_t rd_cmd(input int a);
        cmd_t c = rand_cmd();
        c.rd   = 1'b1;
        c.wr   = 1'b0;
        c.addr = AW'(a);
        return c;
    endfunction

    task automatic drive_masters();
        m0_read = pend0 & c0.rd;  m0_write = pend0 & c0.wr;
        m0_address = c0.addr;  m0_writedata = c0.wdata;  m0_byteenable = c0.be;
        m1_read = pend1 & c1.rd;  m1_write = pend1 & c1.wr;
        m1_address = c1.addr;  m1_writedata = c1.wdata;  m1_byteenable = c1.be;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".grant"}, grant_o, 0);
        check_eq({tag, ".wait0"}, m0_waitrequest, 1);
        check_eq({tag, ".wait1"}, m1_waitrequest, 1);
        check_eq({tag, ".rdv0"}, m0_readdatavalid, 0);
        check_eq({tag, ".rdv1"}, m1_readdatavalid, 0);
        check_eq({tag, ".s_read"}, s_read, 0);
        check_eq({tag, ".s_write"}, s_write, 0);
        check_eq({tag, ".timeout"}, timeout_o, 0);
        check_eq({tag, ".rdata0"}, m0_readdata, exp_rd0);
        check_eq({tag, ".rdata1"}, m1_readdata, exp_rd1);
        check_eq({tag, ".err"}, err_count_o, exp_err);
    endtask

    // Called at the falling edge of an IDLE cycle. k < 0 means the bank never accepts.
    // k = accept cycle, r = read-data cycle, both counted from the first ISSUE cycle.
    task automatic do_txn(input int k, input int r);
        int            w;
        int            e;
        bit            is_wr;
        bit            to;
        cmd_t          c;
        logic [AW-1:0] baddr;
        logic [DW-1:0] exp_data;
        check_quiet("idle");
        drive_masters();
        if (!pend0 && !pend1) begin
            @(negedge clk);
            return;
        end
        if (pend0 && pend1) w = (last_w == 0) ? 1 : 0;
        else                w = pend1 ? 1 : 0;
        c        = w ? c1 : c0;
        is_wr    = c.wr;
        to       = (k < 0);
        e        = to ? TO - 1 : (is_wr ? k : ((k > r) ? k : r));
        exp_data = ref_mem[c.addr];
        baddr    = '0;
        @(negedge clk);
        for (int cyc = 0; cyc <= e; cyc++) begin
            check_eq("iss.grant", grant_o, w ? 2 : 1);
            check_eq("iss.wait0", m0_waitrequest, 1);
            check_eq("iss.wait1", m1_waitrequest, 1);
            check_eq("iss.rdv0", m0_readdatavalid, 0);
            check_eq("iss.rdv1", m1_readdatavalid, 0);
            check_eq("iss.timeout", timeout_o, 0);
            check_eq("iss.s_write", s_write, is_wr && (to || cyc <= k));
            check_eq("iss.s_read", s_read, !is_wr && (to || cyc <= k));
            if (cyc == 0) begin
                check_eq("iss.addr", s_address, c.addr);
                check_eq("iss.wdata", s_writedata, c.wdata);
                check_eq("iss.be", s_byteenable, c.be);
                baddr = s_address;
                // The winner may retract its strobe; the transaction must still finish.
                if ($urandom_range(0, 3) == 0) begin
                    if (w == 1) begin m1_read = 0; m1_write = 0; end
                    else        begin m0_read = 0; m0_write = 0; end
                end
            end
            if (!to && is_wr && cyc == k && s_write) begin
                for (int b = 0; b < BW; b++)
                    if (s_byteenable[b]) bank_mem[s_address][8*b +: 8] = s_writedata[8*b +: 8];
            end
            s_waitrequest   = to || (cyc < k);
            s_readdatavalid = !to && !is_wr && (cyc == r);
            s_readdata      = s_readdatavalid ? bank_mem[baddr] : {$urandom, $urandom};
            @(negedge clk);
        end
        s_waitrequest   = 1'b1;
        s_readdatavalid = 1'b0;
        if (!is_wr) begin
            if (w == 1) exp_rd1 = to ? '1 : exp_data;
            else        exp_rd0 = to ? '1 : exp_data;
        end
        if (to && exp_err < 255) exp_err++;
        check_eq("resp.grant", grant_o, w ? 2 : 1);
        check_eq("resp.wait0", m0_waitrequest, (w == 0) ? 0 : 1);
        check_eq("resp.wait1", m1_waitrequest, (w == 1) ? 0 : 1);
        check_eq("resp.rdv0", m0_readdatavalid, (w == 0) && !is_wr);
        check_eq("resp.rdv1", m1_readdatavalid, (w == 1) && !is_wr);
        check_eq("resp.rdata0", m0_readdata, exp_rd0);
        check_eq("resp.rdata1", m1_readdata, exp_rd1);
        check_eq("resp.timeout", timeout_o, to);
        check_eq("resp.err", err_count_o, exp_err);
        check_eq("resp.strobes", {s_read, s_write}, 0);
        if (!to && is_wr) begin
            for (int b = 0; b < BW; b++)
                if (c.be[b]) ref_mem[c.addr][8*b +: 8] = c.wdata[8*b +: 8];
        end
        last_w = w;
        if (w == 1) pend1 = 0;
        else        pend0 = 0;
        drive_masters();
        @(negedge clk);
        check_quiet("rel");
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        pend0 = 0;  pend1 = 0;
        c0 = '0;  c1 = '0;
        drive_masters();
        s_waitrequest = 1'b1;  s_readdatavalid = 1'b0;  s_readdata = '0;
        last_w = 1;  exp_rd0 = '0;  exp_rd1 = '0;  exp_err = 0;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i]  = {$urandom, $urandom};
            bank_mem[i] = ref_mem[i];
        end
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check_eq("reset.addr", s_address, 0);
        check_eq("reset.wdata", s_writedata, 0);
        check_eq("reset.be", s_byteenable, 0);
        rst = 1'b0;

        // Both masters read continuously with an instant bank: strict alternation from m0.
        for (int i = 0; i < 8; i++) begin
            if (!pend0) begin pend0 = 1; c0 = rd_cmd($urandom_range(0, 15)); end
            if (!pend1) begin pend1 = 1; c1 = rd_cmd($urandom_range(0, 15)); end
            check_eq("alt.expect", last_w, (i == 0) ? 1 : ((i % 2 == 1) ? 0 : 1));
            do_txn(0, 0);
        end

        // m0 write, zero wait states.
        pend1 = 0;  pend0 = 1;
        c0 = '{rd: 1'b0, wr: 1'b1, addr: 10'h008, wdata: 64'h1122334455667788, be: 8'hFF};
        do_txn(0, 0);

        // m1 read held off by five wait states.
        ref_mem[16] = 64'hCAFE;  bank_mem[16] = 64'hCAFE;
        pend1 = 1;  c1 = rd_cmd(16);
        do_txn(5, 5);
        check_eq("cafe.rdata1", m1_readdata, 64'hCAFE);

        // Hung bank: watchdog abort.
        pend0 = 1;  c0 = rd_cmd(3);
        do_txn(-1, 0);
        check_eq("to.err", err_count_o, 1);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            if (!pend0 && $urandom_range(0, 3) != 0) begin pend0 = 1; c0 = rand_cmd(); end
            if (!pend1 && $urandom_range(0, 3) != 0) begin pend1 = 1; c1 = rand_cmd(); end
            if ($urandom_range(0, 19) == 0) do_txn(-1, 0);
            else do_txn($urandom_range(0, 5), $urandom_range(0, 5));
        end

        // Reset on the third ISSUE cycle of a hung read.
        pend1 = 0;  pend0 = 1;  c0 = rd_cmd(5);
        check_quiet("prerst");
        drive_masters();
        s_waitrequest = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("prerst.s_read", s_read, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_w = 1;  exp_rd0 = '0;  exp_rd1 = '0;  exp_err = 0;
        check_eq("rst.s_read", s_read, 0);
        check_eq("rst.rdv0", m0_readdatavalid, 0);
        pend1 = 1;  c1 = rd_cmd(7);
        do_txn(0, 0);
        check_eq("rst.tie_m0", last_w, 0);

        // Saturating error counter.
        for (int i = 0; i < 300; i++) begin
            pend1 = 0;  pend0 = 1;  c0 = rd_cmd($urandom_range(0, 15));
            do_txn(-1, 0);
        end
        check_eq("sat.err", err_count_o, 255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
